// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported data memory (optional macro: DMEM_ARB_FIXED_PRIO_EN).
// Latency: request sampled at edge E -> gnt in cycle E+1 -> done (with rdata) in cycle E+2.
// Backpressure: requesters hold reqN with their command until gntN; one access per 2 cycles.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_BITS-1:0]  addr0,
    input  logic [ADDR_BITS-1:0]  addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_done0;
    logic                  r_done1;
    logic [ADDR_BITS-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_data_in;
    logic                  r_mem_wen;

    logic                  w_any;
    logic                  w_win1;

    assign w_any = req0 | req1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_win1 = req1 & ~req0;
`else
    // On a tie the requester that was not served last wins.
    assign w_win1 = req1 & (~req0 | ~r_last);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_last        <= 1'b1;
            r_gnt0        <= 1'b0;
            r_gnt1        <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_data_in <= '0;
            r_mem_wen     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    if (w_any) begin
                        r_state       <= S_ISSUE;
                        r_mem_addr    <= w_win1 ? addr1  : addr0;
                        r_mem_data_in <= w_win1 ? wdata1 : wdata0;
                        r_mem_wen     <= w_win1 ? we1    : we0;
                        r_gnt0        <= ~w_win1;
                        r_gnt1        <= w_win1;
                        r_last        <= w_win1;
                    end else begin
                        r_state   <= S_IDLE;
                        r_gnt0    <= 1'b0;
                        r_gnt1    <= 1'b0;
                        r_mem_wen <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    // r_last holds the requester granted on entry to ISSUE.
                    r_state   <= S_RESP;
                    r_gnt0    <= 1'b0;
                    r_gnt1    <= 1'b0;
                    r_mem_wen <= 1'b0;
                    r_done0   <= ~r_last;
                    r_done1   <= r_last;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_last        <= 1'b1;
                    r_gnt0        <= 1'b0;
                    r_gnt1        <= 1'b0;
                    r_done0       <= 1'b0;
                    r_done1       <= 1'b0;
                    r_mem_addr    <= '0;
                    r_mem_data_in <= '0;
                    r_mem_wen     <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign mem_addr    = r_mem_addr;
    assign mem_data_in = r_mem_data_in;
    assign mem_wen     = r_mem_wen;
    assign rdata       = mem_data_out;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_dmem_arbiter;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic          we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, done0, done1, mem_wen;
    logic [DW-1:0] rdata, mem_data_in;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_out = '0;

    logic [DW-1:0] tb_mem [32];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_wen(mem_wen), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Behaviour of reg_mem: registered read, zero output on a write cycle.
    always @(posedge clk) begin
        if (mem_wen) begin
            tb_mem[mem_addr] <= mem_data_in;
            mem_data_out     <= '0;
        end else begin
            mem_data_out <= tb_mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_wen, mem_addr, mem_data_in} !== '0) begin
            errors++;
            $display("FAIL reset_values: got g=%b%b d=%b%b wen=%b addr=%0d din=%h, want all 0",
                     gnt0, gnt1, done0, done1, mem_wen, mem_addr, mem_data_in);
        end
        rst = 1;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_wen} !== 5'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got g=%b%b d=%b%b wen=%b, want 0", gnt0, gnt1, done0, done1, mem_wen);
        end
    endtask

    task automatic test_single_read();
        tb_mem[5] = 8'hA7;
        req0 = 1; we0 = 0; addr0 = 5;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_wen, mem_addr} !== {5'b10000, 5'd5}) begin
            errors++;
            $display("FAIL single_read_gnt: got g=%b%b d=%b%b wen=%b addr=%0d, want g=10 d=00 wen=0 addr=5",
                     gnt0, gnt1, done0, done1, mem_wen, mem_addr);
        end
        req0 = 0;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, rdata} !== {4'b0010, 8'hA7}) begin
            errors++;
            $display("FAIL single_read_done: got g=%b%b d=%b%b rdata=%h, want g=00 d=10 rdata=a7",
                     gnt0, gnt1, done0, done1, rdata);
        end
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1} !== 4'b0000) begin
            errors++;
            $display("FAIL single_read_pulse: got g=%b%b d=%b%b, want all 0", gnt0, gnt1, done0, done1);
        end
    endtask

    task automatic test_write_then_read();
        req1 = 1; we1 = 1; addr1 = 17; wdata1 = 8'h3C;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_wen, mem_addr, mem_data_in} !== {5'b01001, 5'd17, 8'h3C}) begin
            errors++;
            $display("FAIL write_gnt: got g=%b%b d=%b%b wen=%b addr=%0d din=%h, want g=01 wen=1 addr=17 din=3c",
                     gnt0, gnt1, done0, done1, mem_wen, mem_addr, mem_data_in);
        end
        req1 = 0; we1 = 0;
        tick();
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_wen, rdata} !== {5'b00010, 8'h00}) begin
            errors++;
            $display("FAIL write_done: got g=%b%b d=%b%b wen=%b rdata=%h, want d=01 wen=0 rdata=00",
                     gnt0, gnt1, done0, done1, mem_wen, rdata);
        end
        req0 = 1; we0 = 0; addr0 = 17;
        tick();
        req0 = 0;
        tick();
        checks++;
        if ({done0, done1, rdata} !== {2'b10, 8'h3C}) begin
            errors++;
            $display("FAIL readback_17: got d=%b%b rdata=%h, want d=10 rdata=3c", done0, done1, rdata);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic          exp_w;
        logic [DW-1:0] exp_rd;
        do_reset();
        tb_mem[1] = 8'h11;
        tb_mem[2] = 8'h22;
        req0 = 1; we0 = 0; addr0 = 1;
        req1 = 1; we1 = 0; addr1 = 2;
        for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            exp_w = 1'b0;
`else
            exp_w = k[0];
`endif
            exp_rd = exp_w ? 8'h22 : 8'h11;
            tick();
            checks++;
            if ({gnt0, gnt1, done0, done1, mem_addr} !== {~exp_w, exp_w, 2'b00, (exp_w ? 5'd2 : 5'd1)}) begin
                errors++;
                $display("FAIL rr_gnt%0d: got g=%b%b d=%b%b addr=%0d, want winner %0d", k,
                         gnt0, gnt1, done0, done1, mem_addr, exp_w);
            end
            tick();
            checks++;
            if ({gnt0, gnt1, done0, done1, rdata} !== {2'b00, ~exp_w, exp_w, exp_rd}) begin
                errors++;
                $display("FAIL rr_done%0d: got g=%b%b d=%b%b rdata=%h, want done %0d rdata=%h", k,
                         gnt0, gnt1, done0, done1, rdata, exp_w, exp_rd);
            end
        end
        req0 = 0;
        tick();
        checks++;
        if ({gnt0, gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL rr_peer_after_drop: got g=%b%b, want 01", gnt0, gnt1);
        end
        req1 = 0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        tb_mem[3] = 8'h33;
        tb_mem[4] = 8'h44;
        req0 = 1; we0 = 0; addr0 = 3;
        tick();
        checks++;
        if ({gnt0, mem_addr} !== {1'b1, 5'd3}) begin
            errors++;
            $display("FAIL b2b_gnt_a: got g0=%b addr=%0d, want 1 / 3", gnt0, mem_addr);
        end
        addr0 = 4;
        tick();
        checks++;
        if ({gnt0, done0, rdata} !== {2'b01, 8'h33}) begin
            errors++;
            $display("FAIL b2b_done_a: got g0=%b d0=%b rdata=%h, want 0 1 33", gnt0, done0, rdata);
        end
        tick();
        checks++;
        if ({gnt0, done0, mem_addr} !== {2'b10, 5'd4}) begin
            errors++;
            $display("FAIL b2b_gnt_b: got g0=%b d0=%b addr=%0d, want 1 0 4", gnt0, done0, mem_addr);
        end
        req0 = 0;
        tick();
        checks++;
        if ({gnt0, done0, rdata} !== {2'b01, 8'h44}) begin
            errors++;
            $display("FAIL b2b_done_b: got g0=%b d0=%b rdata=%h, want 0 1 44", gnt0, done0, rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int done_seen;
        do_reset();
        req0 = 1; we0 = 1; addr0 = 9; wdata0 = 8'hFF;
        tick();
        checks++;
        if ({gnt0, mem_wen} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_issue: got g0=%b wen=%b, want 1 1", gnt0, mem_wen);
        end
        rst = 0;
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, mem_wen, mem_addr, mem_data_in} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got g=%b%b d=%b%b wen=%b addr=%0d din=%h, want all 0",
                     gnt0, gnt1, done0, done1, mem_wen, mem_addr, mem_data_in);
        end
        clear_inputs();
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst = 1;
            tick();
            if (done0 || done1 || gnt0 || gnt1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_done: got %0d active cycles, want 0", done_seen);
        end
        tb_mem[10] = 8'h5A;
        req1 = 1; we1 = 0; addr1 = 10;
        tick();
        req1 = 0;
        checks++;
        if ({gnt0, gnt1, mem_addr} !== {2'b01, 5'd10}) begin
            errors++;
            $display("FAIL midrst_idle_restart: got g=%b%b addr=%0d, want 01 / 10", gnt0, gnt1, mem_addr);
        end
        tick();
        checks++;
        if ({done1, rdata} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL midrst_read: got d1=%b rdata=%h, want 1 5a", done1, rdata);
        end
        tick();
    endtask

    task automatic test_random();
        logic [DW-1:0] m_mem [32];
        logic          m_busy, m_w, m_last, m_we;
        logic          e_g0, e_g1, e_d0, e_d1, e_wen, w;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din, e_rd;
        int            wait0, wait1;
        for (int i = 0; i < 32; i++) begin
            tb_mem[i] = DW'($urandom);
            m_mem[i]  = tb_mem[i];
        end
        do_reset();
        m_busy = 0; m_w = 0; m_last = 1; m_we = 0;
        e_addr = '0; e_din = '0; e_rd = '0;
        e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_wen = 0;
        wait0 = 0; wait1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            // Model: an accepted command takes two cycles (grant, then completion).
            if (m_busy) begin
                e_g0 = 0; e_g1 = 0; e_wen = 0;
                e_d0 = ~m_w; e_d1 = m_w;
                e_rd = m_we ? '0 : m_mem[e_addr];
                if (m_we) m_mem[e_addr] = e_din;
                m_busy = 0;
            end else begin
                e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_wen = 0;
                if (req0 || req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    w = req0 ? 1'b0 : 1'b1;
`else
                    w = (req0 && req1) ? ~m_last : req1;
`endif
                    m_w = w; m_last = w; m_busy = 1;
                    m_we   = w ? we1 : we0;
                    e_addr = w ? addr1 : addr0;
                    e_din  = w ? wdata1 : wdata0;
                    e_wen  = m_we;
                    e_g0 = ~w; e_g1 = w;
                end
            end
            tick();
            checks++;
            if ({gnt0, gnt1, done0, done1, mem_wen, mem_addr, mem_data_in} !==
                {e_g0, e_g1, e_d0, e_d1, e_wen, e_addr, e_din}) begin
                errors++;
                $display("FAIL rand_c%0d: got g=%b%b d=%b%b wen=%b addr=%0d din=%h, want g=%b%b d=%b%b wen=%b addr=%0d din=%h",
                         cyc, gnt0, gnt1, done0, done1, mem_wen, mem_addr, mem_data_in,
                         e_g0, e_g1, e_d0, e_d1, e_wen, e_addr, e_din);
            end
            if (e_d0 || e_d1) begin
                checks++;
                if (rdata !== e_rd) begin
                    errors++;
                    $display("FAIL rand_rdata_c%0d: got %h want %h", cyc, rdata, e_rd);
                end
            end
`ifndef DMEM_ARB_FIXED_PRIO_EN
            wait0 = (req0 && !gnt0) ? wait0 + 1 : 0;
            wait1 = (req1 && !gnt1) ? wait1 + 1 : 0;
            if (wait0 > 4 || wait1 > 4) begin
                checks++;
                errors++;
                $display("FAIL rand_starve_c%0d: waits %0d/%0d, want <= 4", cyc, wait0, wait1);
                wait0 = 0; wait1 = 0;
            end
`endif
            if (!req0 || e_g0) begin
                req0 = ($urandom_range(0, 2) != 0);
                we0 = $urandom_range(0, 1) == 1;
                addr0 = AW'($urandom);
                wdata0 = DW'($urandom);
            end
            if (!req1 || e_g1) begin
                req1 = ($urandom_range(0, 2) != 0);
                we1 = $urandom_range(0, 1) == 1;
                addr1 = AW'($urandom);
                wdata1 = DW'($urandom);
            end
        end
        clear_inputs();
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) tb_mem[i] = '0;
        test_reset();
        test_single_read();
        test_write_then_read();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
